// File: rtl/oport_uart_tx.sv
// CPU output-port to UART bridge: buffers oport writes in a small FIFO and
// shifts each byte out as an 8N1 frame, LSB first.
module oport_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4,
  parameter int COUNT_W      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         oport,
  input  logic               oport_we,
  input  logic               clr_overflow,
  output logic               tx,
  output logic               busy,
  output logic               fifo_full,
  output logic [COUNT_W-1:0] count,
  output logic               overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         mem [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               ovf_q, ovf_d;
  logic               full, wr_en, pop, baud_end, have_data;

  assign full      = (count_q == COUNT_W'(DEPTH));
  assign wr_en     = oport_we & ~full;
  assign have_data = (count_q != '0);
  assign baud_end  = (baud_q == 16'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // chain straight into the next frame so queued bytes leave with no gap
          if (have_data) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
    // a dropped write beats a simultaneous clear
    ovf_d = ovf_q;
    if (oport_we && full) ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= oport;
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign fifo_full = full;
  assign count     = count_q;
  assign overflow  = ovf_q;
endmodule
